// File: rtl/ff_div_pkg.sv
// ff_div_pkg: shared widths, issue FSM states and operand-pair type for the divider issue stage
package ff_div_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_OUT_W = 18;
    typedef enum logic [1:0] {IDLE, ISSUE, OUTPUT} state_t;
    typedef struct packed {
        logic [DEF_WIDTH-1:0] dividend;
        logic [DEF_WIDTH-1:0] divisor;
    } pair_t;
endpackage

// File: rtl/ff_sync_fifo.sv
// ff_sync_fifo: synchronous FIFO with show-ahead read data and occupancy count
module ff_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clock)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/ff_div_issue.sv
// ff_div_issue: queues operand pairs, holds them on the divider for DIV_LATENCY cycles and returns results
module ff_div_issue
    import ff_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OUT_W = DEF_OUT_W,
    parameter int DIV_LATENCY = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [OUT_W-1:0] div_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OUT_W-1:0] res_data,
    output logic             res_err,
    output logic             busy
);
    localparam int CW = $clog2(DIV_LATENCY + 1);
    state_t state, state_next;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] head;
    logic full, empty, push, pop, head_zero, issue_done;
    assign in_ready = !full;
    assign push = in_valid && in_ready;
    assign head_zero = head[WIDTH-1:0] == '0;
    assign issue_done = state == ISSUE && cnt == '0;
    ff_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(2*WIDTH)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din({in_dividend, in_divisor}),
        .dout(head),
        .full(full),
        .empty(empty),
        .count()
    );
    always_ff @(posedge clock)
        state <= reset ? IDLE : state_next;
    always_comb
        state_next = pop ? (head_zero ? OUTPUT : ISSUE)
                   : issue_done ? OUTPUT
                   : (state == OUTPUT && res_ready) ? IDLE : state;
    // Popping straight out of OUTPUT on the handshake edge avoids an IDLE bubble
    always_comb begin
        pop = !empty && (state == IDLE || (state == OUTPUT && res_ready));
        res_valid = state == OUTPUT;
        busy = state != IDLE || !empty;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            div_dividend <= '0;
            div_divisor <= '0;
            res_data <= '0;
            res_err <= 1'b0;
        end else begin
            if (pop && !head_zero) begin
                div_dividend <= head[2*WIDTH-1:WIDTH];
                div_divisor <= head[WIDTH-1:0];
                cnt <= CW'(DIV_LATENCY - 1);
            end else if (state == ISSUE && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (pop && head_zero) begin
                res_data <= '0;
                res_err <= 1'b1;
            end else if (issue_done) begin
                res_data <= div_out;
                res_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ff_div_issue.sv
// tb_ff_div_issue: directed checks of latency, zero-divisor rejection, backpressure, ordering and reset
module tb_ff_div_issue;
    logic clock = 1'b0;
    logic reset, in_valid, in_ready, res_valid, res_ready, res_err, busy;
    logic [7:0] in_dividend, in_divisor, div_dividend, div_divisor;
    logic [17:0] div_out, res_data;
    int n_chk = 0, n_fail = 0, cyc = 0;
    int t0, t1, t2, t3, t4;

    always #5 clock = ~clock;

    // Divider model: a fixed answer for 0x0B/0x06, otherwise a tagged echo of the operands
    assign div_out = (div_dividend == 8'h0B && div_divisor == 8'h06) ? 18'h0ABCD
                   : {2'b01, div_dividend, div_divisor};

    ff_div_issue dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_out(div_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err), .busy(busy)
    );

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] dd, input logic [7:0] dv);
        in_valid = 1'b1;
        in_dividend = dd;
        in_divisor = dv;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [17:0] ed, input logic ee, output int t);
        int w = 0;
        while (!res_valid && w < 30) begin
            tick();
            w++;
        end
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_data"}, 32'(res_data), 32'(ed));
        chk({tag, "_err"}, 32'(res_err), 32'(ee));
        t = cyc;
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_err"}, 32'(res_err), 32'd0);
        chk({tag, "_res_data"}, 32'(res_data), 32'd0);
        chk({tag, "_div_dividend"}, 32'(div_dividend), 32'd0);
        chk({tag, "_div_divisor"}, 32'(div_divisor), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_dividend = '0;
        in_divisor = '0;
        res_ready = 1'b1;
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b0;
        tick();

        // Zero divisor: rejected after the pop edge, divider inputs untouched
        push(8'h0B, 8'h00);
        chk("zero_e0_valid", 32'(res_valid), 32'd0);
        chk("zero_e0_busy", 32'(busy), 32'd1);
        tick();
        chk("zero_e1_valid", 32'(res_valid), 32'd1);
        chk("zero_e1_err", 32'(res_err), 32'd1);
        chk("zero_e1_data", 32'(res_data), 32'd0);
        chk("zero_div_dividend", 32'(div_dividend), 32'd0);
        chk("zero_div_divisor", 32'(div_divisor), 32'd0);
        tick();
        chk("zero_done_valid", 32'(res_valid), 32'd0);
        chk("zero_done_busy", 32'(busy), 32'd0);

        // Single op: result valid after E1+DIV_LATENCY
        push(8'h0B, 8'h06);
        tick();
        chk("single_e1_dividend", 32'(div_dividend), 32'h0B);
        chk("single_e1_divisor", 32'(div_divisor), 32'h06);
        chk("single_e1_valid", 32'(res_valid), 32'd0);
        tick();
        tick();
        tick();
        chk("single_e4_valid", 32'(res_valid), 32'd0);
        chk("single_e4_dividend", 32'(div_dividend), 32'h0B);
        tick();
        chk("single_e5_valid", 32'(res_valid), 32'd1);
        chk("single_e5_data", 32'(res_data), 32'h0ABCD);
        chk("single_e5_err", 32'(res_err), 32'd0);
        chk("single_e5_divisor", 32'(div_divisor), 32'h06);
        tick();
        chk("single_done_valid", 32'(res_valid), 32'd0);
        chk("single_done_busy", 32'(busy), 32'd0);

        // Fill and backpressure: first pair issued, four fill the queue, sixth refused
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("fill_in_ready", 32'(in_ready), 32'd1);
            push(8'(8'h10 + i), 8'(i + 1));
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_dividend = 8'h99;
        in_divisor = 8'h07;
        tick();
        chk("full_held_in_ready", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        // Result stall: output must hold for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_valid", 32'(res_valid), 32'd1);
            chk("stall_data", 32'(res_data), 32'h11001);
            chk("stall_err", 32'(res_err), 32'd0);
        end
        res_ready = 1'b1;
        get_result("bp0", 18'h11001, 1'b0, t0);
        get_result("bp1", 18'h11102, 1'b0, t1);
        get_result("bp2", 18'h11203, 1'b0, t2);
        get_result("bp3", 18'h11304, 1'b0, t3);
        get_result("bp4", 18'h11405, 1'b0, t4);
        chk("bp_gap1", 32'(t1 - t0), 32'd5);
        chk("bp_gap2", 32'(t2 - t1), 32'd5);
        chk("bp_gap3", 32'(t3 - t2), 32'd5);
        chk("bp_gap4", 32'(t4 - t3), 32'd5);
        tick();
        chk("bp_no_extra_valid", 32'(res_valid), 32'd0);
        chk("bp_idle_busy", 32'(busy), 32'd0);

        // Mixed ordering including an error entry
        push(8'h0B, 8'h06);
        push(8'h03, 8'h00);
        push(8'h55, 8'h01);
        get_result("mix0", 18'h0ABCD, 1'b0, t0);
        get_result("mix1", 18'h00000, 1'b1, t1);
        get_result("mix2", 18'h15501, 1'b0, t2);
        chk("mix_err_gap", 32'(t1 - t0), 32'd1);
        chk("mix_third_gap", 32'(t2 - t1), 32'd5);
        tick();
        chk("mix_idle_busy", 32'(busy), 32'd0);

        // Reset while issuing (cnt=2) with two pairs still queued
        push(8'h21, 8'h02);
        push(8'h22, 8'h03);
        push(8'h23, 8'h04);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("midreset");
        tick();
        tick();
        chk("midreset_quiet_valid", 32'(res_valid), 32'd0);
        chk("midreset_quiet_busy", 32'(busy), 32'd0);
        push(8'h55, 8'h01);
        tick();
        chk("post_e1_dividend", 32'(div_dividend), 32'h55);
        tick();
        tick();
        tick();
        chk("post_e4_valid", 32'(res_valid), 32'd0);
        tick();
        chk("post_e5_valid", 32'(res_valid), 32'd1);
        chk("post_e5_data", 32'(res_data), 32'h15501);
        tick();
        chk("post_done_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
